// File: rtl/player_position_updater_if.sv
// Controller-side handshake and pixel-write bus of the player position updater.
interface player_position_updater_if;
    logic       setleft;
    logic       setright;
    logic       setup;
    logic       setdown;
    logic       update_player;
    logic       doneUpdate_player;
    logic [7:0] x_pos;
    logic [6:0] y_pos;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;
    logic       busy;

    modport master (
        output setleft, setright, setup, setdown, update_player,
        input  doneUpdate_player, x_pos, y_pos, vga_x, vga_y, vga_colour, plot, busy
    );

    modport slave (
        input  setleft, setright, setup, setdown, update_player,
        output doneUpdate_player, x_pos, y_pos, vga_x, vga_y, vga_colour, plot, busy
    );
endinterface

// File: rtl/player_position_updater.sv
// Erases the 4x4 player sprite, applies one latched move with edge clamping,
// then redraws it; pixel writes stream out on the vga_* bus.
module player_position_updater #(
    parameter int unsigned SCREEN_W      = 160,
    parameter int unsigned SCREEN_H      = 120,
    parameter int unsigned SPRITE        = 4,
    parameter int unsigned STEP          = 1,
    parameter int unsigned START_X       = 78,
    parameter int unsigned START_Y       = 58,
    parameter logic [2:0]  PLAYER_COLOUR = 3'b111,
    parameter logic [2:0]  BG_COLOUR     = 3'b000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    player_position_updater_if.slave bus
);

    typedef enum logic [2:0] {IDLE, ERASE, MOVE, DRAW, DONE} state_t;
    typedef enum logic [2:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT, DIR_UP, DIR_DOWN} dir_t;

    // Clamp arithmetic runs one bit wider than the position registers.
    localparam logic [8:0] X_MAX  = 9'(SCREEN_W - SPRITE);
    localparam logic [7:0] Y_MAX  = 8'(SCREEN_H - SPRITE);
    localparam logic [8:0] STEP_X = 9'(STEP);
    localparam logic [7:0] STEP_Y = 8'(STEP);

    state_t     state, state_next;
    dir_t       dir, dir_next;
    logic [3:0] cnt, cnt_next;
    logic [7:0] x_pos, x_next;
    logic [6:0] y_pos, y_next;
    logic [8:0] x_wide, x_sum, x_diff;
    logic [7:0] y_wide, y_sum, y_diff;

    logic       plot, done, busy;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            dir   <= DIR_NONE;
            x_pos <= 8'(START_X);
            y_pos <= 7'(START_Y);
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            dir   <= dir_next;
            x_pos <= x_next;
            y_pos <= y_next;
        end
    end

    always_comb begin
        x_wide = {1'b0, x_pos};
        y_wide = {1'b0, y_pos};
        x_sum  = x_wide + STEP_X;
        y_sum  = y_wide + STEP_Y;
        x_diff = x_wide - STEP_X;
        y_diff = y_wide - STEP_Y;
    end

    // Outputs decode only registered state, so strobes never reach the pixel bus.
    always_comb begin
        state_next = state;
        dir_next   = dir;
        cnt_next   = '0;
        x_next     = x_pos;
        y_next     = y_pos;
        plot       = 1'b0;
        done       = 1'b0;
        busy       = 1'b1;
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.setleft)       dir_next = DIR_LEFT;
                else if (bus.setright) dir_next = DIR_RIGHT;
                else if (bus.setup)    dir_next = DIR_UP;
                else if (bus.setdown)  dir_next = DIR_DOWN;
                if (bus.update_player) state_next = ERASE;
            end
            ERASE, DRAW: begin
                plot       = 1'b1;
                vga_x      = x_pos + {6'b0, cnt[1:0]};
                vga_y      = y_pos + {5'b0, cnt[3:2]};
                vga_colour = (state == ERASE) ? BG_COLOUR : PLAYER_COLOUR;
                cnt_next   = cnt + 4'd1;
                if (cnt == 4'd15) state_next = (state == ERASE) ? MOVE : DONE;
            end
            MOVE: begin
                dir_next   = DIR_NONE;
                state_next = DRAW;
                case (dir)
                    DIR_LEFT:  x_next = (x_wide >= STEP_X) ? x_diff[7:0] : '0;
                    DIR_RIGHT: x_next = (x_sum > X_MAX) ? X_MAX[7:0] : x_sum[7:0];
                    DIR_UP:    y_next = (y_wide >= STEP_Y) ? y_diff[6:0] : '0;
                    DIR_DOWN:  y_next = (y_sum > Y_MAX) ? Y_MAX[6:0] : y_sum[6:0];
                    default:   ;
                endcase
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.plot              = plot;
    assign bus.doneUpdate_player = done;
    assign bus.busy              = busy;
    assign bus.vga_x             = vga_x;
    assign bus.vga_y             = vga_y;
    assign bus.vga_colour        = vga_colour;
    assign bus.x_pos             = x_pos;
    assign bus.y_pos             = y_pos;

endmodule

// File: tb/tb_player_position_updater.sv
// Directed bench: every cycle of each update is compared against the expected
// erase/move/draw/done sequence, with edge clamping and mid-operation reset.
module tb_player_position_updater;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    player_position_updater_if bus();

    player_position_updater #(
        .SCREEN_W(160), .SCREEN_H(120), .SPRITE(4), .STEP(1),
        .START_X(78), .START_Y(58),
        .PLAYER_COLOUR(3'b111), .BG_COLOUR(3'b000)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] mx;
    logic [6:0] my;

    logic [35:0] obs;
    assign obs = {bus.plot, bus.doneUpdate_player, bus.busy, bus.vga_x, bus.vga_y,
                  bus.vga_colour, bus.x_pos, bus.y_pos};

    typedef struct {
        logic [3:0] strobes;   // {left, right, up, down}
        logic [7:0] ex;
        logic [6:0] ey;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [35:0] expv(input logic p, input logic d, input logic b,
                                         input logic [7:0] vx, input logic [6:0] vy,
                                         input logic [2:0] col, input logic [7:0] px,
                                         input logic [6:0] py);
        return {p, d, b, vx, vy, col, px, py};
    endfunction

    task automatic run_update(input string tag, input logic [3:0] strobes,
                              input logic [7:0] nx, input logic [6:0] ny,
                              input bit busy_strobe, input bit drop_early);
        logic [7:0] ox;
        logic [6:0] oy;
        logic [35:0] e;
        int unsigned c;
        ox = mx;
        oy = my;
        @(posedge clk); #1;
        {bus.setleft, bus.setright, bus.setup, bus.setdown} = strobes;
        @(posedge clk); #1;
        {bus.setleft, bus.setright, bus.setup, bus.setdown} = 4'b0000;
        bus.update_player = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            @(posedge clk); #1;
            if (k <= 16) begin
                c = k - 1;
                e = expv(1'b1, 1'b0, 1'b1, ox + 8'(c % 4), oy + 7'(c / 4), 3'b000, ox, oy);
            end else if (k == 17) begin
                e = expv(1'b0, 1'b0, 1'b1, 8'd0, 7'd0, 3'b000, ox, oy);
            end else if (k <= 33) begin
                c = k - 18;
                e = expv(1'b1, 1'b0, 1'b1, nx + 8'(c % 4), ny + 7'(c / 4), 3'b111, nx, ny);
            end else if (k == 34) begin
                e = expv(1'b0, 1'b1, 1'b1, 8'd0, 7'd0, 3'b000, nx, ny);
            end else begin
                e = expv(1'b0, 1'b0, 1'b0, 8'd0, 7'd0, 3'b000, nx, ny);
            end
            check($sformatf("%s_c%0d", tag, k), obs, e);
            if (k == 34 || (drop_early && k == 2)) bus.update_player = 1'b0;
            if (busy_strobe) bus.setdown = (k == 5);
        end
        mx = nx;
        my = ny;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4'b0100, 8'd79, 7'd58};  // right from reset position
        vecs[1] = '{4'b1000, 8'd78, 7'd58};  // left
        vecs[2] = '{4'b0010, 8'd78, 7'd57};  // up
        vecs[3] = '{4'b0001, 8'd78, 7'd58};  // down
        vecs[4] = '{4'b1010, 8'd77, 7'd58};  // left beats up
        vecs[5] = '{4'b0101, 8'd78, 7'd58};  // right beats down
        vecs[6] = '{4'b0011, 8'd78, 7'd57};  // up beats down
        vecs[7] = '{4'b0000, 8'd78, 7'd57};  // no direction: redraw in place
        vecs[8] = '{4'b1111, 8'd77, 7'd57};  // left wins all
        vecs[9] = '{4'b0001, 8'd77, 7'd58};  // down

        reset_n = 1'b0;
        bus.update_player = 1'b1;
        {bus.setleft, bus.setright, bus.setup, bus.setdown} = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", obs, expv(1'b0, 1'b0, 1'b0, 8'd0, 7'd0, 3'b000, 8'd78, 7'd58));
        bus.update_player = 1'b0;
        {bus.setleft, bus.setright, bus.setup, bus.setdown} = 4'b0000;
        reset_n = 1'b1;
        mx = 8'd78;
        my = 7'd58;

        for (int i = 0; i < 10; i++)
            run_update($sformatf("vec%0d", i), vecs[i].strobes, vecs[i].ex, vecs[i].ey, 1'b0, 1'b0);

        run_update("busy_strobe", 4'b0000, 8'd77, 7'd58, 1'b1, 1'b0);
        run_update("drop_early", 4'b0100, 8'd78, 7'd58, 1'b0, 1'b1);

        for (int i = 0; i < 78; i++)
            run_update($sformatf("walkL%0d", i), 4'b1000, mx - 8'd1, my, 1'b0, 1'b0);
        run_update("left_at_x0", 4'b1000, 8'd0, my, 1'b0, 1'b0);
        for (int i = 0; i < 58; i++)
            run_update($sformatf("walkU%0d", i), 4'b0010, mx, my - 7'd1, 1'b0, 1'b0);
        run_update("up_at_y0", 4'b0010, 8'd0, 7'd0, 1'b0, 1'b0);
        run_update("left_at_origin", 4'b1000, 8'd0, 7'd0, 1'b0, 1'b0);

        for (int i = 0; i < 156; i++)
            run_update($sformatf("walkR%0d", i), 4'b0100, mx + 8'd1, my, 1'b0, 1'b0);
        run_update("right_at_max", 4'b0100, 8'd156, my, 1'b0, 1'b0);
        for (int i = 0; i < 116; i++)
            run_update($sformatf("walkD%0d", i), 4'b0001, mx, my + 7'd1, 1'b0, 1'b0);
        run_update("down_at_max", 4'b0001, 8'd156, 7'd116, 1'b0, 1'b0);
        run_update("right_at_corner", 4'b0100, 8'd156, 7'd116, 1'b0, 1'b0);

        // Reset during ERASE, with a direction still latched.
        @(posedge clk); #1;
        bus.setright = 1'b1;
        @(posedge clk); #1;
        bus.setright = 1'b0;
        bus.update_player = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        bus.update_player = 1'b0;
        @(posedge clk); #1;
        check("mid_reset", obs, expv(1'b0, 1'b0, 1'b0, 8'd0, 7'd0, 3'b000, 8'd78, 7'd58));
        reset_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            check($sformatf("post_reset_idle%0d", k), obs,
                  expv(1'b0, 1'b0, 1'b0, 8'd0, 7'd0, 3'b000, 8'd78, 7'd58));
        end
        mx = 8'd78;
        my = 7'd58;
        run_update("dir_cleared_by_reset", 4'b0000, 8'd78, 7'd58, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
